// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_ctrl_pkg
// Description : Shared definitions for the HI/LO multiply/divide sequencer:
//               register-bus width, operation encodings, FSM state encodings
//               and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_muldiv_ctrl_pkg;

  // Width of the general register bus; HI/LO match it.
  localparam int REG_BUS_W = 16;
  localparam int MD_DW     = REG_BUS_W;
  // Iteration counter width; must be able to hold MD_DW.
  localparam int MD_CW     = 5;

  // Operation encodings as delivered by EX.
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit 1 of the encoding selects divide, bit 0 selects signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iteration datapath for the HI/LO sequencer. Holds the
//               magnitude accumulator, performs one shift-add (multiply) or
//               one restoring-division step per step_i, applies the sign
//               fix-up and captures the final HI/LO on finish_i.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load_i        - capture operand magnitudes and sign flags
//               step_i        - perform one iteration
//               finish_i      - capture results (same edge as the last step)
//               dz_i          - divide-by-zero result on finish_i
//               op_i/opa_i/opb_i - operation and raw operands
//               hi_o/lo_o     - registered HI/LO results
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DW = MD_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          finish_i,
  input  logic          dz_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] opa_i,
  input  logic [DW-1:0] opb_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW-1:0] acc_hi_q, acc_hi_d;
  logic [DW-1:0] acc_lo_q, acc_lo_d;
  logic [DW-1:0] b_q, b_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;     // negate product / quotient
  logic          rneg_q, rneg_d;   // negate remainder (dividend negative)
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  logic [DW-1:0]   a_mag, b_mag;
  logic [DW:0]     sum, rem_sh, diff;
  logic [DW-1:0]   step_hi, step_lo, quot, rem;
  logic [2*DW-1:0] prod;

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_mag = (op_is_signed(op_i) && opa_i[DW-1]) ? -opa_i : opa_i;
    b_mag = (op_is_signed(op_i) && opb_i[DW-1]) ? -opb_i : opb_i;

    // Multiply step: {carry, hi} += multiplicand when multiplier LSB set,
    // then the whole {carry, hi, lo} shifts right by one.
    sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(DW+1){1'b0}});

    // Divide step: {rem, quot} << 1. The shifted remainder needs one extra
    // bit, but after a successful subtract it always fits back into DW.
    rem_sh = {acc_hi_q, acc_lo_q[DW-1]};
    diff   = rem_sh - {1'b0, b_q};

    if (is_div_q) begin
      if (rem_sh >= {1'b0, b_q}) begin
        step_hi = diff[DW-1:0];
        step_lo = {acc_lo_q[DW-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[DW-1:0];
        step_lo = {acc_lo_q[DW-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[DW:1];
      step_lo = {sum[0], acc_lo_q[DW-1:1]};
    end

    // Sign fix-up on the post-step value so it lands on the DONE edge.
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    quot = neg_q  ? -step_lo : step_lo;
    rem  = rneg_q ? -step_hi : step_hi;

    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = a_mag;
      b_d      = b_mag;
      is_div_d = op_is_div(op_i);
      neg_d    = op_is_signed(op_i) && (opa_i[DW-1] ^ opb_i[DW-1]);
      rneg_d   = op_is_signed(op_i) && op_is_div(op_i) && opa_i[DW-1];
    end else if (step_i) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
    end

    if (finish_i) begin
      if (dz_i) begin
        hi_d = opa_i;
        lo_d = '1;
      end else if (is_div_q) begin
        hi_d = rem;
        lo_d = quot;
      end else begin
        hi_d = prod[2*DW-1:DW];
        lo_d = prod[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO.
//               Stalls the pipeline while iterating, then pulses we_o for
//               one cycle with the results.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               start      - request from EX (sampled in IDLE only)
//               op         - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//               opa, opb   - multiplicand/dividend, multiplier/divisor
//               cancel     - pipeline flush, aborts any operation
//               stall_o    - pipeline stall request
//               busy_o     - state != IDLE
//               we_o       - HI/LO write-enable pulse
//               hi_o, lo_o - HI/LO results
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DW = MD_DW,
  parameter int CW = MD_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          cancel,
  output logic          stall_o,
  output logic          busy_o,
  output logic          we_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, finish, dz;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    dz      = 1'b0;

    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            load  = 1'b1;
            cnt_d = '0;
            if (op_is_div(op) && (opb == '0)) begin
              state_d = ST_DONE;
              finish  = 1'b1;
              dz      = 1'b1;
            end else begin
              state_d = op_is_div(op) ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign stall_o = ((state_q == ST_IDLE) && start && !cancel) ||
                   (state_q == ST_MUL) || (state_q == ST_DIV);
  // A flush in DONE suppresses the write even though results are captured.
  assign we_o    = (state_q == ST_DONE) && !cancel;

  muldiv_iter #(
    .DW(DW)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (step),
    .finish_i(finish),
    .dz_i    (dz),
    .op_i    (op),
    .opa_i   (opa),
    .opb_i   (opb),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_ctrl
// Description : Self-checking bench for hilo_muldiv_ctrl. Stimulus pushes the
//               expected HI/LO pair into a scoreboard; a monitor pops and
//               compares on every we_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

  localparam int DW = 16;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          cancel;
  logic          stall_o;
  logic          busy_o;
  logic          we_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*DW-1:0] sb_q[$];

  hilo_muldiv_ctrl #(
    .DW(DW),
    .CW(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .cancel (cancel),
    .stall_o(stall_o),
    .busy_o (busy_o),
    .we_o   (we_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (we_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we: got hi/lo %h%h expected no write", hi_o, lo_o);
      end else begin
        chk("hilo_result", {hi_o, lo_o}, sb_q.pop_front());
      end
    end
  end

  // Issue an operation at the current cycle N and check stall/we timing;
  // lat is the cycle offset of the write pulse (17, or 1 for divide by 0).
  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ehi, input logic [DW-1:0] elo, input int lat);
    logic ok;
    sb_q.push_back({ehi, elo});
    start = 1'b1; op = o; opa = a; opb = b;
    #1;
    chk("stall_cycle_n", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c < lat; c++) begin
      if (stall_o !== 1'b1 || we_o !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    if (lat > 1) chk("stall_window", {31'd0, ok}, 32'd1);
    chk("we_stall_done", {30'd0, we_o, stall_o}, 32'b10);
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {29'd0, busy_o, stall_o, we_o}, 32'd0);
    chk("reset_hilo", {hi_o, lo_o}, 32'h0000_0000);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 17); // MULTU
    run_op(2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 17); // MULT -3*5
    run_op(2'b01, 16'hFFF8, 16'hFFFA, 16'h0000, 16'h0030, 17); // MULT -8*-6
    run_op(2'b10, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 17); // DIVU 100/7
    run_op(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 17); // DIV -7/2
    run_op(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 17); // DIV overflow
    run_op(2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1);  // DIVU by zero

    // Cancel during a multiply: no write, HI/LO keep the previous result.
    start = 1'b1; op = 2'b00; opa = 16'h0003; opb = 16'h0004;
    @(posedge clk); #1;                     // cycle N+1
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                     // cycle N+5
    cancel = 1'b1;
    #1;
    chk("we_during_cancel", {31'd0, we_o}, 32'd0);
    @(posedge clk); #1;                     // cycle N+6
    cancel = 1'b0;
    chk("busy_after_cancel", {31'd0, busy_o}, 32'd0);
    chk("hilo_kept_cancel", {hi_o, lo_o}, 32'h1234_FFFF);
    @(posedge clk); #1;                     // cycle N+7
    run_op(2'b00, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 17);

    // Reset in the middle of a divide: state and results cleared, no write.
    start = 1'b1; op = 2'b10; opa = 16'h0064; opb = 16'h0007;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;                                     // cycle N+8
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("busy_after_rst", {31'd0, busy_o}, 32'd0);
    chk("hilo_after_rst", {hi_o, lo_o}, 32'h0000_0000);
    repeat (20) @(posedge clk);
    #1;

    // DIV by zero on a signed dividend, after the reset recovery.
    run_op(2'b11, 16'h8001, 16'h0000, 16'h8001, 16'hFFFF, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
